// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath.
// IR fields and flags flow in; datapath enables and status flow out.
interface multicycle_ctrl_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegDst;
  logic       Link;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       Jump;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic       illegal;
  logic       timeout;

  modport master (
    input  OP, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, IorD,
    output MemRead, MemWrite, RegDst,
    output Link, ALUSrc, MemtoReg,
    output RegWrite, Jump, ALUOp,
    output state, illegal, timeout
  );

  modport slave (
    output OP, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, IorD,
    input  MemRead, MemWrite, RegDst,
    input  Link, ALUSrc, MemtoReg,
    input  RegWrite, Jump, ALUOp,
    input  state, illegal, timeout
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: fetch/decode/exec/mem/wb
// sequencing over a shared memory port with timeout and illegal traps.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_JAL      = 1'b1
) (
  input logic          clk,
  input logic          reset,
  multicycle_ctrl_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_ADDU, C_SUBU, C_ORI,
    C_LW, C_SW, C_BEQ, C_JAL
  } cls_t;

  state_t        st, st_n;
  cls_t          cls, cls_n, dcls;
  logic [CW-1:0] cnt, cnt_n;
  logic          ill, ill_n;
  logic          tmo, tmo_n;
  logic          last;

  assign last = (cnt == CW'(MEM_TIMEOUT - 1));

  // classify the instruction register fields
  always_comb begin
    dcls = C_NONE;
    unique case (bus.OP)
      6'b000000: begin
        if (bus.Funct == 6'b100001)
          dcls = C_ADDU;
        else if (bus.Funct == 6'b100011)
          dcls = C_SUBU;
      end
      6'b001101: dcls = C_ORI;
      6'b100011: dcls = C_LW;
      6'b101011: dcls = C_SW;
      6'b000100: dcls = C_BEQ;
      6'b000011: if (EN_JAL) dcls = C_JAL;
      default:   dcls = C_NONE;
    endcase
  end

  // next state, wait counter and sticky traps
  always_comb begin
    st_n  = st;
    cls_n = cls;
    cnt_n = '0;
    ill_n = ill;
    tmo_n = tmo;
    unique case (st)
      FETCH, MEM: begin
        if (bus.mem_ready) begin
          if (st == FETCH)
            st_n = DECODE;
          else if (cls == C_LW)
            st_n = WB;
          else
            st_n = FETCH;
        end else if (last) begin
          st_n  = TRAP;
          tmo_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DECODE: begin
        cls_n = dcls;
        if (dcls == C_NONE) begin
          st_n  = TRAP;
          ill_n = 1'b1;
        end else begin
          st_n = EXEC;
        end
      end
      EXEC: begin
        unique case (cls)
          C_ADDU, C_SUBU, C_ORI: st_n = WB;
          C_LW, C_SW:            st_n = MEM;
          default:               st_n = FETCH;
        endcase
      end
      WB:      st_n = FETCH;
      TRAP:    st_n = TRAP;
      default: st_n = FETCH;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      cls <= C_NONE;
      cnt <= '0;
      ill <= 1'b0;
      tmo <= 1'b0;
    end else begin
      st  <= st_n;
      cls <= cls_n;
      cnt <= cnt_n;
      ill <= ill_n;
      tmo <= tmo_n;
    end
  end

  // datapath enables, forced low while reset is held
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegDst   = 1'b0;
    bus.Link     = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Jump     = 1'b0;
    bus.ALUOp    = 2'b00;
    if (!reset) begin
      unique case (st)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        EXEC: begin
          unique case (cls)
            C_ADDU: bus.RegDst = 1'b1;
            C_SUBU: begin
              bus.RegDst = 1'b1;
              bus.ALUOp  = 2'b01;
            end
            C_ORI: begin
              bus.ALUSrc = 1'b1;
              bus.ALUOp  = 2'b10;
            end
            C_LW, C_SW: bus.ALUSrc = 1'b1;
            C_BEQ: begin
              bus.ALUOp   = 2'b01;
              bus.PCWrite = bus.Zero;
            end
            C_JAL: begin
              bus.Jump     = 1'b1;
              bus.PCWrite  = 1'b1;
              bus.Link     = 1'b1;
              bus.RegWrite = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.IorD     = 1'b1;
          bus.MemRead  = (cls == C_LW);
          bus.MemWrite = (cls == C_SW);
        end
        WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = (cls == C_ADDU) ||
                         (cls == C_SUBU);
          bus.MemtoReg = (cls == C_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.illegal = ill;
  assign bus.timeout = tmo;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction
// cycle-sequence model derived from the instruction class rules.
module tb_multicycle_ctrl;

  localparam int T = 4;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LW,
    K_SW, K_BEQ, K_JAL, K_ILL
  } kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, iord, mr, mw;
    logic rd, lk, as, m2r, rw, j;
    logic [1:0] aop;
    logic il, to;
  } ov_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_ctrl_if a();
  multicycle_ctrl_if b();

  multicycle_ctrl #(
    .MEM_TIMEOUT(T),
    .EN_JAL(1'b1)
  ) u0 (
    .clk(clk),
    .reset(reset),
    .bus(a)
  );

  multicycle_ctrl #(
    .MEM_TIMEOUT(15),
    .EN_JAL(1'b0)
  ) u1 (
    .clk(clk),
    .reset(reset),
    .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic ov_t obs();
    ov_t o;
    o.st   = a.state;
    o.pcw  = a.PCWrite;
    o.irw  = a.IRWrite;
    o.iord = a.IorD;
    o.mr   = a.MemRead;
    o.mw   = a.MemWrite;
    o.rd   = a.RegDst;
    o.lk   = a.Link;
    o.as   = a.ALUSrc;
    o.m2r  = a.MemtoReg;
    o.rw   = a.RegWrite;
    o.j    = a.Jump;
    o.aop  = a.ALUOp;
    o.il   = a.illegal;
    o.to   = a.timeout;
    return o;
  endfunction

  function automatic logic b_any_en();
    return b.PCWrite | b.IRWrite | b.IorD |
           b.MemRead | b.MemWrite | b.RegDst |
           b.Link | b.ALUSrc | b.MemtoReg |
           b.RegWrite | b.Jump | (|b.ALUOp);
  endfunction

  function automatic kind_t classify(
      input logic [5:0] op, input logic [5:0] fn,
      input bit en_jal);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return K_ADDU;
      if (fn == 6'b100011) return K_SUBU;
      return K_ILL;
    end
    if (op == 6'b001101) return K_ORI;
    if (op == 6'b100011) return K_LW;
    if (op == 6'b101011) return K_SW;
    if (op == 6'b000100) return K_BEQ;
    if (op == 6'b000011 && en_jal) return K_JAL;
    return K_ILL;
  endfunction

  // one clock cycle: drive at posedge+1, check at negedge
  task automatic cyc(input logic rdy,
                     input logic [5:0] op,
                     input logic [5:0] fn,
                     input logic z,
                     input ov_t e,
                     input string tag);
    a.mem_ready = rdy;
    a.OP        = op;
    a.Funct     = fn;
    a.Zero      = z;
    @(negedge clk);
    chk(tag, 32'(obs()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic rcyc(input ov_t e, input string tag);
    cyc(1'($urandom), 6'($urandom), 6'($urandom),
        1'($urandom), e, tag);
  endtask

  task automatic trap_cycles(input logic il,
                             input logic to);
    ov_t e;
    for (int i = 0; i < 2; i++) begin
      e = '0;
      e.st = 3'd7;
      e.il = il;
      e.to = to;
      rcyc(e, "trap");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    a.mem_ready = 1'b1;
    a.Zero = 1'b1;
    #2;
    chk("rst", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // memory access of w wait cycles; returns 1 if it timed out
  task automatic access(input ov_t base,
                        input int w,
                        input string tag,
                        output bit tmo);
    ov_t e;
    tmo = 1'b0;
    for (int i = 0; i < 64; i++) begin
      e = base;
      if (i == w && base.st == 3'd0) begin
        e.pcw = 1'b1;
        e.irw = 1'b1;
      end
      cyc(i == w, 6'($urandom), 6'($urandom),
          1'($urandom), e, tag);
      if (i == w) return;
      if (i == T - 1) begin
        trap_cycles(1'b0, 1'b1);
        tmo = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn,
                           input logic zb,
                           input int wf,
                           input int wm,
                           output bit trapped);
    kind_t k;
    ov_t   e;
    bit    tmo;
    k = classify(op, fn, 1'b1);
    trapped = 1'b0;
    e = '0;
    e.mr = 1'b1;
    access(e, wf, "fetch", tmo);
    if (tmo) begin
      trapped = 1'b1;
      return;
    end
    e = '0;
    e.st = 3'd1;
    cyc(1'($urandom), op, fn, 1'($urandom), e, "decode");
    if (k == K_ILL) begin
      trap_cycles(1'b1, 1'b0);
      trapped = 1'b1;
      return;
    end
    e = '0;
    e.st = 3'd2;
    case (k)
      K_ADDU: e.rd = 1'b1;
      K_SUBU: begin e.rd = 1'b1; e.aop = 2'd1; end
      K_ORI:  begin e.as = 1'b1; e.aop = 2'd2; end
      K_LW, K_SW: e.as = 1'b1;
      K_BEQ:  begin e.aop = 2'd1; e.pcw = zb; end
      K_JAL:  begin
        e.j = 1'b1; e.pcw = 1'b1;
        e.lk = 1'b1; e.rw = 1'b1;
      end
      default: ;
    endcase
    cyc(1'($urandom), 6'($urandom), 6'($urandom),
        zb, e, "exec");
    if (k == K_BEQ || k == K_JAL) return;
    if (k == K_LW || k == K_SW) begin
      e = '0;
      e.st = 3'd3;
      e.iord = 1'b1;
      e.mr = (k == K_LW);
      e.mw = (k == K_SW);
      access(e, wm, "mem", tmo);
      if (tmo) begin
        trapped = 1'b1;
        return;
      end
      if (k == K_SW) return;
    end
    e = '0;
    e.st = 3'd4;
    e.rw = 1'b1;
    e.rd = (k == K_ADDU || k == K_SUBU);
    e.m2r = (k == K_LW);
    rcyc(e, "wb");
  endtask

  task automatic run(input logic [5:0] op,
                     input logic [5:0] fn,
                     input logic zb,
                     input int wf,
                     input int wm);
    bit tr;
    run_instr(op, fn, zb, wf, wm, tr);
    if (tr) do_reset();
  endtask

  function automatic int rwait();
    int r;
    r = $urandom_range(0, 15);
    if (r < 10) return 0;
    if (r < 14) return $urandom_range(1, T - 1);
    return $urandom_range(T, T + 2);
  endfunction

  logic [5:0] ops [7];
  logic [5:0] rop, rfn;
  ov_t        e;

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b000000;
    ops[2] = 6'b001101; ops[3] = 6'b100011;
    ops[4] = 6'b101011; ops[5] = 6'b000100;
    ops[6] = 6'b000011;
    a.OP = '0; a.Funct = '0;
    a.Zero = 1'b0; a.mem_ready = 1'b1;
    b.OP = 6'b000011; b.Funct = '0;
    b.Zero = 1'b0; b.mem_ready = 1'b1;
    reset = 1'b1;
    #3;
    chk("rst0", 32'(obs()), 32'd0);
    chk("b_rst0", 32'(b.state), 32'd0);

    // JAL trapped as illegal when disabled
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("b_fetch", 32'(b.state), 32'd0);
    @(negedge clk);
    chk("b_decode", 32'(b.state), 32'd1);
    chk("b_il_pre", 32'(b.illegal), 32'd0);
    @(negedge clk);
    chk("b_trap", 32'(b.state), 32'd7);
    chk("b_il", 32'(b.illegal), 32'd1);
    chk("b_en", 32'(b_any_en()), 32'd0);
    @(negedge clk);
    chk("b_hold", 32'(b.state), 32'd7);
    chk("b_en2", 32'(b_any_en()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("b_il_clr", 32'(b.illegal), 32'd0);
    chk("b_st_clr", 32'(b.state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    do_reset();
    run(6'b000000, 6'b100001, 1'b0, 0, 0);
    run(6'b000000, 6'b100011, 1'b1, 0, 0);
    run(6'b100011, 6'd0, 1'b0, 0, 3);
    run(6'b000100, 6'd0, 1'b1, 0, 0);
    run(6'b000100, 6'd0, 1'b0, 0, 0);
    run(6'b000011, 6'd0, 1'b0, 1, 0);
    run(6'b001101, 6'd5, 1'b0, 2, 0);
    run(6'b101011, 6'd0, 1'b0, 0, T - 1);
    run(6'b000000, 6'b000000, 1'b0, 0, 0);
    run(6'b100011, 6'd0, 1'b0, 0, 9);
    run(6'b000000, 6'b100001, 1'b0, 9, 0);
    run(6'b000000, 6'b100001, 1'b0, T - 1, 0);

    // asynchronous reset in the middle of an SW access
    e = '0; e.mr = 1'b1; e.pcw = 1'b1; e.irw = 1'b1;
    cyc(1'b1, 6'd0, 6'd0, 1'b0, e, "sw_fetch");
    e = '0; e.st = 3'd1;
    cyc(1'b0, 6'b101011, 6'd0, 1'b0, e, "sw_dec");
    e = '0; e.st = 3'd2; e.as = 1'b1;
    cyc(1'b0, 6'd0, 6'd0, 1'b0, e, "sw_exec");
    e = '0; e.st = 3'd3; e.iord = 1'b1; e.mw = 1'b1;
    cyc(1'b0, 6'd0, 6'd0, 1'b0, e, "sw_mem");
    a.mem_ready = 1'b0;
    #1;
    chk("sw_mw_pre", 32'(a.MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("sw_mw_rst", 32'(a.MemWrite), 32'd0);
    chk("sw_all_rst", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(6'b000000, 6'b100001, 1'b0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rfn = 6'($urandom);
      if (sel < 7) begin
        rop = ops[sel];
        if (sel == 0) rfn = 6'b100001;
        if (sel == 1) rfn = 6'b100011;
      end else if (sel == 7) begin
        rop = 6'b000000;
      end else begin
        rop = 6'($urandom);
      end
      run(rop, rfn, 1'($urandom), rwait(), rwait());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
